// File: rtl/cacheline_adaptor_p.sv
// cacheline_adaptor_p: splits/assembles a cacheline into memory bursts for fills and writebacks
module cacheline_adaptor_p #(
  parameter int s_line  = 256,
  parameter int s_burst = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [s_line-1:0]  line_i,
  output logic [s_line-1:0]  line_o,
  input  logic [31:0]        address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  input  logic [s_burst-1:0] burst_i,
  output logic [s_burst-1:0] burst_o,
  output logic [31:0]        address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
);
  localparam int BEATS = s_line / s_burst;
  localparam int CW = $clog2(BEATS);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [31:0] addr_q;
  logic [s_line-1:0] wline_q, fill_q;
  logic last;
  assign last = resp_i && cnt == CW'(BEATS - 1);
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state == IDLE ? (write_i ? WRITE : read_i ? READ : IDLE)
            : state == DONE ? IDLE
            : last ? DONE : state;
  end
  always_comb begin
    read_o    = state == READ;
    write_o   = state == WRITE;
    resp_o    = state == DONE;
    burst_o   = state == WRITE ? wline_q[cnt*s_burst +: s_burst] : '0;
    address_o = addr_q;
    line_o    = fill_q;
  end
  // cnt wraps to 0 naturally on the final beat
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      addr_q  <= '0;
      wline_q <= '0;
      fill_q  <= '0;
    end else if (state == IDLE) begin
      if (write_i || read_i) begin
        addr_q <= address_i & 32'hFFFF_FFE0;
        cnt    <= '0;
      end
      if (write_i) wline_q <= line_i;
    end else if ((state == READ || state == WRITE) && resp_i) begin
      cnt <= cnt + CW'(1);
      if (state == READ) fill_q[cnt*s_burst +: s_burst] <= burst_i;
    end
  end
endmodule

// File: doc/cacheline_adaptor_p.md
# cacheline_adaptor_p

Memory-side stage directly downstream of the pipelined cache datapath. It converts one 256-bit cacheline transfer into a sequence of 64-bit bursts on the physical memory port. A read request (line fill) collects four beats into a line. A write request (dirty writeback) splits the line into four beats. The cache controller sees a single `resp_o` pulse when the whole transfer is complete.

## Interface
Parameters:
- `s_line`, 256, cacheline width in bits.
- `s_burst`, 64, memory beat width in bits. `BEATS = s_line/s_burst` (4); must be a power of two ≥ 2.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `line_i`  in  s_line  writeback data from the cache (the datapath's `cacheline_data_out`).
- `line_o`  out  s_line  fill data to the cache (the datapath's `data_from_mem`).
- `address_i`  in  32  line address from the cache (the datapath's `address_to_mem`).
- `read_i`  in  1  line-fill request; held by the cache until `resp_o`.
- `write_i`  in  1  writeback request; held by the cache until `resp_o`.
- `resp_o`  out  1  one-cycle completion pulse.
- `burst_i`  in  s_burst  read beat from memory.
- `burst_o`  out  s_burst  write beat to memory.
- `address_o`  out  32  latched address with bits [4:0] forced to 0.
- `read_o`  out  1  memory read strobe.
- `write_o`  out  1  memory write strobe.
- `resp_i`  in  1  memory beat-valid / beat-accepted.

## Operation
- States: IDLE, READ, WRITE, DONE. A 2-bit beat counter `cnt` (log2 BEATS bits) tracks the current beat.
- IDLE
  - On a rising edge with `write_i`=1: latch `address_i` and `line_i`, clear `cnt`, go to WRITE.
  - Else, with `read_i`=1: latch `address_i`, clear `cnt`, go to READ.
  - If `read_i` and `write_i` are both 1, the write takes priority; the read is serviced after DONE if the cache still holds it.
  - `resp_i` is ignored in IDLE.
- READ
  - `read_o`=1.
  - On each edge with `resp_i`=1: store `burst_i` into line bits [64·cnt+63 : 64·cnt] and increment `cnt`.
  - Cycles with `resp_i`=0 are stalls: no state change.
  - When the beat with `cnt`=BEATS-1 is stored, go to DONE.
- WRITE
  - `write_o`=1 and `burst_o` = latched line bits [64·cnt+63 : 64·cnt].
  - On each edge with `resp_i`=1, increment `cnt`.
  - After beat BEATS-1 is accepted, go to DONE.
- DONE
  - `resp_o`=1 for exactly one cycle, then go to IDLE unconditionally.
- Strobes and data outputs:
  - `read_o`/`write_o` stay high continuously from entry to READ/WRITE until the cycle that carries the last beat; they are 0 in IDLE and DONE.
  - `burst_o` is 0 outside WRITE.
- `line_o` is driven from the fill register. It is valid while `resp_o`=1 and holds its value until the next READ overwrites beat 0. Writebacks do not modify the fill register.
- `address_o` holds the latched address for the whole transaction, including DONE, and holds it afterwards until the next request is latched.
- Reset mid-burst aborts the transfer: go to IDLE with no `resp_o`, and drive strobes low the cycle after `rst` is sampled. Memory-side cleanup is the memory model's responsibility.
- Counter wrap: `cnt` wraps BEATS-1→0 on the final beat. It is also cleared on entry to READ/WRITE.

## Timing
- Values held during and after reset:
  - state IDLE, `cnt`=0.
  - `resp_o`, `read_o`, `write_o` = 0.
  - `burst_o`, `address_o`, `line_o` = 0.
- Request sampled at edge 0 → strobe high in cycle 1.
- If `resp_i` is high on cycles 1–4, the last beat lands at edge 4 and `resp_o` is high in cycle 5. Minimum latency from request to `resp_o` is therefore BEATS+1 cycles.
- Each stall cycle (`resp_i`=0 while in READ/WRITE) adds one cycle.
- Earliest next request sampling is at the end of cycle 6 (back in IDLE). A request still asserted in DONE is not re-sampled until IDLE.
- Outputs that are a function of state only (no combinational input→output paths):
  - `read_o`, `write_o`, `resp_o`: decoded from state.
  - `burst_o`: a mux of registered data on `cnt`.

## Test plan
- Line fill, no stalls:
  - Stimulus: `read_i`, `address_i`=0x0000_1234; memory returns beats 0x0…0, 0x1…1, 0x2…2, 0x3…3 on consecutive cycles.
  - Required: `address_o`=0x0000_1220; `read_o` high for 4 cycles; `resp_o` pulses in cycle 5; `line_o`={0x3…3, 0x2…2, 0x1…1, 0x0…0}.
- Writeback with stalls:
  - Stimulus: `line_i`={D3,D2,D1,D0}; `resp_i` pattern 1,0,1,0,0,1,1.
  - Required: `burst_o` shows D0, D1, D1, D2, D2, D2, D3 in the corresponding cycles; `write_o` high 7 cycles; single `resp_o` one cycle later.
- Simultaneous `read_i`=`write_i`=1:
  - Required: WRITE runs first; `read_o` stays 0 until after `resp_o`; the held read then completes as a second transaction.
- Reset asserted during the second beat of a READ:
  - Required: no `resp_o`; `read_o`=0 and all outputs 0 the following cycle.
  - Then: a fresh read completes normally with `cnt` starting at beat 0.
- Back-to-back fill then writeback:
  - Required: `line_o` retains the fill data throughout the writeback; `resp_i` pulses while in IDLE are ignored (no state change).
